// File: rtl/bus_arbiter_rr_pkg.sv
// Shared AZPR bus arbitration types: owner index width, master indices,
// arbiter state encoding and active-low signal levels.
package bus_arbiter_rr_pkg;

    localparam int unsigned BUS_OWNER_W = 2;
    typedef logic [BUS_OWNER_W-1:0] bus_owner_bus_t;

    localparam bus_owner_bus_t BUS_MASTER_0 = 2'd0;
    localparam bus_owner_bus_t BUS_MASTER_1 = 2'd1;
    localparam bus_owner_bus_t BUS_MASTER_2 = 2'd2;
    localparam bus_owner_bus_t BUS_MASTER_3 = 2'd3;

    typedef enum logic {
        BUS_ARB_STATE_IDLE  = 1'b0,
        BUS_ARB_STATE_GRANT = 1'b1
    } bus_arb_state_e;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin pick: first active-high requester after owner_i,
// wrapping, with owner_i itself searched last.
module bus_arb_rr_pick
    import bus_arbiter_rr_pkg::*;
(
    input  logic [3:0]     req_i,
    input  bus_owner_bus_t owner_i,
    output bus_owner_bus_t pick_o,
    output logic           valid_o
);

    bus_owner_bus_t idx;

    // Walk from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        pick_o  = owner_i;
        valid_o = 1'b0;
        idx     = owner_i;
        for (int k = 4; k >= 1; k--) begin
            idx = owner_i + bus_owner_bus_t'(k);
            if (req_i[idx]) begin
                pick_o  = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the four AZPR bus masters with ownership held until
// release and a bounded-tenure yield request.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int unsigned MAX_TENURE = 16,
    parameter int unsigned TENURE_W   = 8
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic       m_yield_,
    output logic [1:0] owner,
    output logic       bus_busy
);

    localparam logic [TENURE_W-1:0] MaxCnt = TENURE_W'(MAX_TENURE);

    bus_arb_state_e      state_q, state_d;
    bus_owner_bus_t      owner_q, owner_d;
    logic [TENURE_W-1:0] cnt_q, cnt_d;
    logic [3:0]          grnt_q, grnt_d;
    logic                yield_q, yield_d;
    logic                busy_q, busy_d;

    logic [3:0]     req;
    logic [3:0]     owner_oh;
    logic           others_wait;
    logic           keep;
    bus_owner_bus_t pick;
    logic           pick_valid;

    assign req         = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_oh    = 4'b0001 << owner_q;
    assign others_wait = |(req & ~owner_oh);
    assign keep        = (state_q == BUS_ARB_STATE_GRANT) && req[owner_q];

    bus_arb_rr_pick u_pick (
        .req_i   (req),
        .owner_i (owner_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = '0;
        unique case (state_q)
            BUS_ARB_STATE_IDLE: begin
                if (pick_valid) begin
                    state_d = BUS_ARB_STATE_GRANT;
                    owner_d = pick;
                end
            end
            BUS_ARB_STATE_GRANT: begin
                if (keep) begin
                    cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
                end else if (pick_valid) begin
                    // Released owner's req_ is high, so pick never returns it here.
                    owner_d = pick;
                end else begin
                    state_d = BUS_ARB_STATE_IDLE;
                end
            end
            default: state_d = BUS_ARB_STATE_IDLE;
        endcase

        grnt_d = {4{DISABLE_}};
        if (state_d == BUS_ARB_STATE_GRANT) begin
            grnt_d[owner_d] = ENABLE_;
        end
        busy_d  = (state_d == BUS_ARB_STATE_GRANT);
        yield_d = (keep && (cnt_d == MaxCnt) && others_wait) ? ENABLE_ : DISABLE_;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q <= BUS_ARB_STATE_IDLE;
            owner_q <= BUS_MASTER_0;
            cnt_q   <= '0;
            grnt_q  <= {4{DISABLE_}};
            yield_q <= DISABLE_;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grnt_q  <= grnt_d;
            yield_q <= yield_d;
            busy_q  <= busy_d;
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];
    assign m_yield_ = yield_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed and random checks of bus_arbiter_rr (MAX_TENURE=4) against a
// cycle-level ownership model.
module tb_bus_arbiter_rr;

    localparam int MaxT = 4;

    logic       clk = 1'b0;
    logic       reset_;
    logic [3:0] req_n;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic       m_yield_;
    logic [1:0] owner;
    logic       bus_busy;

    int total = 0;
    int bad   = 0;

    // Model: who owns the bus, whether it is held, and for how many cycles.
    int m_owner;
    bit m_busy;
    int m_held;
    bit m_yield_low;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .MAX_TENURE (MaxT),
        .TENURE_W   (8)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .m0_req_  (req_n[0]),
        .m1_req_  (req_n[1]),
        .m2_req_  (req_n[2]),
        .m3_req_  (req_n[3]),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .m_yield_ (m_yield_),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    task automatic model_edge();
        bit kept;
        bit others;
        int win;
        kept = 0;
        win  = -1;
        if (!reset_) begin
            m_owner     = 0;
            m_busy      = 0;
            m_held      = 0;
            m_yield_low = 0;
            return;
        end
        if (m_busy && !req_n[m_owner]) begin
            kept = 1;
            m_held++;
        end else begin
            // Nearest requester after the owner wins; a live owner never re-wins.
            for (int d = 4; d >= 1; d--) begin
                if (!req_n[(m_owner + d) % 4] && !(m_busy && d == 4)) win = (m_owner + d) % 4;
            end
            if (win >= 0) begin
                m_owner = win;
                m_busy  = 1;
                m_held  = 1;
            end else begin
                m_busy = 0;
                m_held = 0;
            end
        end
        others = 0;
        for (int i = 0; i < 4; i++) begin
            if (i != m_owner && !req_n[i]) others = 1;
        end
        m_yield_low = kept && (m_held > MaxT) && others;
    endtask

    task automatic check(input string tag);
        logic [3:0] exp_g;
        logic [3:0] got_g;
        exp_g = m_busy ? ~(4'b0001 << m_owner) : 4'b1111;
        got_g = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
        total += 4;
        assert (got_g === exp_g) else begin
            bad++;
            $error("FAIL %s grnt_ observed=%b expected=%b", tag, got_g, exp_g);
        end
        assert (owner === 2'(m_owner)) else begin
            bad++;
            $error("FAIL %s owner observed=%0d expected=%0d", tag, owner, m_owner);
        end
        assert (bus_busy === m_busy) else begin
            bad++;
            $error("FAIL %s bus_busy observed=%b expected=%b", tag, bus_busy, m_busy);
        end
        assert (m_yield_ === !m_yield_low) else begin
            bad++;
            $error("FAIL %s m_yield_ observed=%b expected=%b", tag, m_yield_, !m_yield_low);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        reset_ = 1'b0;
        req_n  = 4'b0000;

        // Reset with every master requesting, then search starts at master 1.
        repeat (3) step("reset");
        reset_ = 1'b1;
        step("reset_release");

        // Round-robin: each owner drops req_ for one cycle after 4 granted cycles.
        for (int g = 0; g < 5; g++) begin
            repeat (3) step("rr_hold");
            req_n[m_owner] = 1'b1;
            step("rr_handover");
            req_n = 4'b0000;
        end
        req_n = 4'b1111;
        repeat (2) step("rr_drain");

        // Single requester m2 for 5 cycles.
        req_n = 4'b1011;
        repeat (5) step("single_m2");
        req_n = 4'b1111;
        repeat (3) step("single_idle");

        // Tenure: m0 holds 10 cycles, m3 joins from cycle 2.
        req_n = 4'b1110;
        step("tenure_c1");
        req_n = 4'b0110;
        repeat (9) step("tenure_hold");
        req_n = 4'b0111;
        repeat (3) step("tenure_handover");
        req_n = 4'b1111;
        repeat (2) step("tenure_idle");

        // Owner drops for one cycle and re-requests alone.
        req_n = 4'b1101;
        repeat (3) step("rereq_hold");
        req_n = 4'b1111;
        step("rereq_drop");
        req_n = 4'b1101;
        repeat (3) step("rereq_again");

        // Mid-ownership reset pulse while m1 keeps requesting.
        reset_ = 1'b0;
        step("mid_reset");
        reset_ = 1'b1;
        repeat (3) step("mid_reset_after");

        // Random traffic: requests toggle with 1/4 probability, rare resets.
        req_n = 4'b1111;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) req_n[i] = ~req_n[i];
            end
            reset_ = ($urandom_range(99) != 0);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
